// File: rtl/grf_scoreboard_mp_if.sv
// Bus bundle for grf_scoreboard_mp: read ports, issue-side claim, write-back port and trace drain.
// Signal prefixes are from the register file's point of view (i_ = into it, o_ = out of it).
interface grf_scoreboard_mp_if #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NRD         = 2,
  parameter int TRACE_DEPTH = 8
);
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

  logic [NRD*ADDR_W-1:0] i_rd_addr;
  logic [NRD*DATA_W-1:0] o_rd_data;
  logic [NRD-1:0]        o_rd_busy;
  logic                  i_claim_en;
  logic [ADDR_W-1:0]     i_claim_addr;
  logic                  i_wr_en;
  logic [ADDR_W-1:0]     i_wr_addr;
  logic [DATA_W-1:0]     i_wr_data;
  logic [31:0]           i_wr_pc;
  logic                  o_trace_valid;
  logic                  i_trace_ready;
  logic [31:0]           o_trace_pc;
  logic [ADDR_W-1:0]     o_trace_addr;
  logic [DATA_W-1:0]     o_trace_data;
  logic [CNT_W-1:0]      o_trace_count;
  logic                  o_trace_overflow;

  modport slave (
    input  i_rd_addr, i_claim_en, i_claim_addr, i_wr_en, i_wr_addr, i_wr_data, i_wr_pc,
           i_trace_ready,
    output o_rd_data, o_rd_busy, o_trace_valid, o_trace_pc, o_trace_addr, o_trace_data,
           o_trace_count, o_trace_overflow
  );

  modport master (
    output i_rd_addr, i_claim_en, i_claim_addr, i_wr_en, i_wr_addr, i_wr_data, i_wr_pc,
           i_trace_ready,
    input  o_rd_data, o_rd_busy, o_trace_valid, o_trace_pc, o_trace_addr, o_trace_data,
           o_trace_count, o_trace_overflow
  );
endinterface

// File: rtl/grf_scoreboard_mp.sv
// General register file with NRD combinational read ports, one write port, optional
// write-to-read bypass, per-register busy bits and a trace FIFO logging every write.
module grf_scoreboard_mp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NRD         = 2,
  parameter int BYPASS      = 1,
  parameter int TRACE_DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  grf_scoreboard_mp_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic [31:0]       r_fifo_pc   [TRACE_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [TRACE_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [TRACE_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_eff_wr;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NRD-1:0]        w_rd_busy;

  assign w_eff_wr = bus.i_wr_en && (bus.i_wr_addr != '0);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(TRACE_DEPTH));
  assign w_pop    = !w_empty && bus.i_trace_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push   = w_eff_wr && (!w_full || w_pop);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_byp;
    assign w_addr = bus.i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_byp  = (BYPASS != 0) && w_eff_wr && (bus.i_wr_addr == w_addr);
    assign w_rd_data[k*DATA_W +: DATA_W] = (w_addr == '0) ? '0 :
                                           w_byp ? bus.i_wr_data : r_regs[w_addr];
    assign w_rd_busy[k] = (w_addr != '0) && !w_byp && r_busy[w_addr];
  end

  assign bus.o_rd_data = w_rd_data;
  assign bus.o_rd_busy = w_rd_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_eff_wr) begin
      // NOTE: state uses non-blocking assignments so every reader sees pre-edge values.
      r_regs[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_eff_wr) r_busy[bus.i_wr_addr] <= 1'b0;
      // Later assignment wins: a same-cycle claim marks the new producer pending.
      if (bus.i_claim_en && (bus.i_claim_addr != '0)) r_busy[bus.i_claim_addr] <= 1'b1;
    end
  end

  // NOTE: payload arrays are not reset; r_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo_pc[r_wr_ptr]   <= bus.i_wr_pc;
      r_fifo_addr[r_wr_ptr] <= bus.i_wr_addr;
      r_fifo_data[r_wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_eff_wr && !w_push)   r_overflow <= 1'b1;
    end
  end

  assign bus.o_trace_valid    = !w_empty;
  assign bus.o_trace_pc       = r_fifo_pc[r_rd_ptr];
  assign bus.o_trace_addr     = r_fifo_addr[r_rd_ptr];
  assign bus.o_trace_data     = r_fifo_data[r_rd_ptr];
  assign bus.o_trace_count    = r_count;
  assign bus.o_trace_overflow = r_overflow;
endmodule

// File: tb/tb_grf_scoreboard_mp.sv
// Self-checking bench for grf_scoreboard_mp: a bypassing and a non-bypassing instance share
// stimulus; trace records are predicted into a queue and compared as they drain.
module tb_grf_scoreboard_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_scoreboard_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .TRACE_DEPTH(DEPTH)) b1 ();
  grf_scoreboard_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .TRACE_DEPTH(DEPTH)) b0 ();

  grf_scoreboard_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .BYPASS(1), .TRACE_DEPTH(DEPTH))
    u_dut_byp (.clk(clk), .reset(reset), .bus(b1.slave));
  grf_scoreboard_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .BYPASS(0), .TRACE_DEPTH(DEPTH))
    u_dut_nobyp (.clk(clk), .reset(reset), .bus(b0.slave));

  assign b0.i_rd_addr     = b1.i_rd_addr;
  assign b0.i_claim_en    = b1.i_claim_en;
  assign b0.i_claim_addr  = b1.i_claim_addr;
  assign b0.i_wr_en       = b1.i_wr_en;
  assign b0.i_wr_addr     = b1.i_wr_addr;
  assign b0.i_wr_data     = b1.i_wr_data;
  assign b0.i_wr_pc       = b1.i_wr_pc;
  assign b0.i_trace_ready = b1.i_trace_ready;

  int n_cmp = 0;
  int n_err = 0;
  rec_t q[$];
  logic [DW-1:0] m_regs [1<<AW];
  logic m_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    b1.i_rd_addr = '0; b1.i_claim_en = 1'b0; b1.i_claim_addr = '0;
    b1.i_wr_en = 1'b0; b1.i_wr_addr = '0; b1.i_wr_data = '0; b1.i_wr_pc = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] pc);
    b1.i_wr_en = 1'b1; b1.i_wr_addr = a; b1.i_wr_data = d; b1.i_wr_pc = pc;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    b1.i_rd_addr = {a1, a0};
  endtask

  // One clock: check state against the model, score any pop, predict any push, advance.
  task automatic cycle();
    rec_t e;
    #1;
    check("trace_count", b1.o_trace_count, q.size());
    check("trace_overflow", b1.o_trace_overflow, m_ovf);
    if (reset) begin
      @(posedge clk);
      q.delete();
      for (int i = 0; i < (1 << AW); i++) m_regs[i] = '0;
      m_ovf = 1'b0;
      @(negedge clk);
      return;
    end
    if (b1.i_trace_ready) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        check("trace_valid", b1.o_trace_valid, 1'b1);
        check("trace_pc", b1.o_trace_pc, e.pc);
        check("trace_addr", b1.o_trace_addr, e.addr);
        check("trace_data", b1.o_trace_data, e.data);
      end else begin
        check("trace_valid_empty", b1.o_trace_valid, 1'b0);
      end
    end
    if (b1.i_wr_en && b1.i_wr_addr != '0) begin
      m_regs[b1.i_wr_addr] = b1.i_wr_data;
      e.pc = b1.i_wr_pc; e.addr = b1.i_wr_addr; e.data = b1.i_wr_data;
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    b1.i_trace_ready = 1'b1;
    for (int n = 0; n < 3 * DEPTH && q.size() != 0; n++) cycle();
    b1.i_trace_ready = 1'b0;
    #1 check("drain_count", b1.o_trace_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) m_regs[i] = '0;
    idle();
    b1.i_trace_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;

    // Reset state
    set_rd(5, 9);
    #1 check("rst_valid", b1.o_trace_valid, 1'b0);
    check("rst_rd5", b1.o_rd_data[0 +: DW], 0);
    check("rst_busy", b1.o_rd_busy, 2'b00);

    // Basic write, readback and trace record
    wr(5, 32'h1234, 32'h3000); cycle();
    idle(); set_rd(5, 0);
    #1 check("rd_r5", b1.o_rd_data[0 +: DW], 32'h1234);
    check("rd_r0_p1", b1.o_rd_data[DW +: DW], 0);
    b1.i_trace_ready = 1'b1; cycle(); b1.i_trace_ready = 1'b0;

    // Writes and claims to r0 are ignored
    wr(0, 32'hFFFF, 32'h3004); b1.i_claim_en = 1'b1; b1.i_claim_addr = '0; cycle();
    idle(); set_rd(0, 0);
    #1 check("rd_r0", b1.o_rd_data, 0);
    check("busy_r0", b1.o_rd_busy, 2'b00);
    check("r0_no_trace", b1.o_trace_count, 0);

    // Bypass vs stored value
    wr(7, 32'h11, 32'h3008); cycle();
    wr(7, 32'hAA, 32'h300C); set_rd(0, 7);
    #1 check("byp_rd_r7", b1.o_rd_data[DW +: DW], 32'hAA);
    check("nobyp_rd_r7", b0.o_rd_data[DW +: DW], 32'h11);
    cycle(); idle(); set_rd(0, 7);
    #1 check("nobyp_rd_r7_next", b0.o_rd_data[DW +: DW], 32'hAA);

    // Busy bits
    b1.i_claim_en = 1'b1; b1.i_claim_addr = 3; set_rd(3, 3);
    #1 check("claim_not_yet", b1.o_rd_busy, 2'b00);
    cycle(); idle(); set_rd(3, 3);
    #1 check("busy_r3", b1.o_rd_busy, 2'b11);
    wr(3, 32'h33, 32'h3010);
    #1 check("byp_busy_clr", b1.o_rd_busy, 2'b00);
    check("nobyp_busy_held", b0.o_rd_busy, 2'b11);
    cycle(); idle(); set_rd(3, 3);
    #1 check("busy_r3_cleared", b1.o_rd_busy, 2'b00);
    check("nobyp_busy_cleared", b0.o_rd_busy, 2'b00);
    wr(3, 32'h34, 32'h3014); b1.i_claim_en = 1'b1; b1.i_claim_addr = 3; cycle();
    idle(); set_rd(3, 1);
    #1 check("claim_wins", b1.o_rd_busy, 2'b01);
    wr(3, 32'h35, 32'h3018); cycle();
    drain();

    // Overflow: nine writes into an eight-deep FIFO with no consumer
    for (int i = 1; i <= 9; i++) begin
      wr(AW'(i), DW'(32'h0101 * i), 32'h4000 + 32'(4 * i)); cycle();
    end
    idle();
    #1 check("full_count", b1.o_trace_count, DEPTH);
    check("ovf_set", b1.o_trace_overflow, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      set_rd(AW'(i), AW'(10 - i));
      #1 check("rd_pat_p0", b1.o_rd_data[0 +: DW], m_regs[i]);
      check("rd_pat_p1", b1.o_rd_data[DW +: DW], m_regs[10 - i]);
    end
    wr(10, 32'hA0A0, 32'h5000); b1.i_trace_ready = 1'b1; cycle();
    idle(); b1.i_trace_ready = 1'b0;
    #1 check("full_pushpop_count", b1.o_trace_count, DEPTH);
    drain();

    // Reset in mid-operation
    wr(1, 32'h1, 32'h6000); cycle();
    wr(2, 32'h2, 32'h6004); cycle();
    wr(4, 32'h4, 32'h6008); cycle();
    wr(9, 32'h55, 32'h600C); b1.i_claim_en = 1'b1; b1.i_claim_addr = 3; cycle();
    idle(); set_rd(3, 9);
    #1 check("pre_rst_count", b1.o_trace_count, 4);
    check("pre_rst_busy", b1.o_rd_busy[0], 1'b1);
    check("pre_rst_r9", b1.o_rd_data[DW +: DW], 32'h55);
    reset = 1'b1; wr(6, 32'h66, 32'h6010); cycle();
    reset = 1'b0; idle(); set_rd(3, 9);
    #1 check("post_rst_count", b1.o_trace_count, 0);
    check("post_rst_ovf", b1.o_trace_overflow, 1'b0);
    check("post_rst_busy", b1.o_rd_busy, 2'b00);
    check("post_rst_r9", b1.o_rd_data[DW +: DW], 0);
    check("post_rst_valid", b1.o_trace_valid, 1'b0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
